// File: rtl/aperture_regs.sv
// aperture_regs: descriptor register file and page_map commit sequencer for the $D6xx aperture window
`ifndef OP_NONE
`define OP_NONE  2'd0
`endif
`ifndef OP_SET
`define OP_SET   2'd1
`endif
`ifndef OP_CLEAR
`define OP_CLEAR 2'd2
`endif

module aperture_regs #(
   parameter int NUM_AP      = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic              clk200_i,
   input  logic              a8_rst_n_i,
   input  logic              wr_strobe_i,
   input  logic [7:0]        wr_addr_i,
   input  logic [7:0]        wr_data_i,
   input  logic [7:0]        rd_addr_i,
   output logic [7:0]        rd_data_o,
   output logic [1:0]        map_op_o,
   output logic [7:0]        map_from_o,
   output logic [7:0]        map_size_o,
   input  logic              map_valid_i,
   output logic              busy_o,
   output logic [NUM_AP-1:0] ap_enable_o,
   output logic              ack_err_o
);
   localparam int KW    = (NUM_AP > 1) ? $clog2(NUM_AP) : 1;
   localparam int AW    = KW + 4;
   localparam int DEPTH = NUM_AP * 16;
   localparam int TW    = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, CLR, CLR_W, SET_CHK, SET, SET_W} state_e;

   logic [7:0]        desc_q [DEPTH];
   logic [7:0]        rd_data_q;
   logic [NUM_AP-1:0] pending_q, pending_d;
   state_e            state_q, state_d;
   logic [KW-1:0]     cur_q, cur_d, sel_k;
   logic              new_en_q, new_en_d;
   logic [7:0]        new_from_q, new_from_d, new_size_q, new_size_d;
   logic [NUM_AP-1:0] act_en_q, act_en_d;
   logic [7:0]        act_from_q [NUM_AP];
   logic [7:0]        act_from_d [NUM_AP];
   logic [7:0]        act_size_q [NUM_AP];
   logic [7:0]        act_size_d [NUM_AP];
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              ack_err_q, ack_err_d;
   logic              wr_hit, ctrl_hit, ack_ok, wait_tout, wait_done;
   logic [8:0]        room;
   logic [7:0]        sel_from, sel_size;

   assign wr_hit      = wr_strobe_i && (int'(wr_addr_i) < DEPTH);
   assign ctrl_hit    = wr_hit && (wr_addr_i[3:0] == 4'hF);
   assign rd_data_o   = rd_data_q;
   assign busy_o      = (state_q != IDLE) || (|pending_q);
   assign ap_enable_o = act_en_q;
   assign ack_err_o   = ack_err_q;

   // Descriptor bytes and registered readback; a same-cycle write is seen on the next read
   always_ff @(posedge clk200_i) begin
      if (!a8_rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) desc_q[i] <= '0;
         rd_data_q <= '0;
      end else begin
         if (wr_hit) desc_q[wr_addr_i[AW-1:0]] <= wr_data_i;
         rd_data_q <= (int'(rd_addr_i) < DEPTH) ? desc_q[rd_addr_i[AW-1:0]] : '0;
      end
   end

   // Commit sequencer: pick lowest pending aperture, clear its old range, then map the new one
   always_comb begin
      sel_k = '0;
      for (int i = NUM_AP - 1; i >= 0; i--)
         if (pending_q[i]) sel_k = KW'(i);
      sel_from   = desc_q[{sel_k, 4'h4}];
      sel_size   = desc_q[{sel_k, 4'h5}];
      room       = 9'd256 - {1'b0, sel_from};
      ack_ok     = (tmr_q != '0) && map_valid_i;
      wait_tout  = !ack_ok && (tmr_q == TW'(ACK_TIMEOUT - 1));
      wait_done  = ack_ok || wait_tout;
      state_d    = state_q;
      pending_d  = pending_q;
      cur_d      = cur_q;
      new_en_d   = new_en_q;
      new_from_d = new_from_q;
      new_size_d = new_size_q;
      act_en_d   = act_en_q;
      act_from_d = act_from_q;
      act_size_d = act_size_q;
      tmr_d      = '0;
      ack_err_d  = ack_err_q;
      map_op_o   = `OP_NONE;
      map_from_o = '0;
      map_size_o = '0;
      case (state_q)
         IDLE: if (|pending_q) begin
            pending_d[sel_k] = 1'b0;
            cur_d            = sel_k;
            new_en_d         = desc_q[{sel_k, 4'hF}][0];
            new_from_d       = sel_from;
            new_size_d       = ({1'b0, sel_size} > room) ? room[7:0] : sel_size;
            state_d          = (act_en_q[sel_k] && act_size_q[sel_k] != '0) ? CLR : SET_CHK;
         end
         CLR: begin
            map_op_o   = `OP_CLEAR;
            map_from_o = act_from_q[cur_q];
            map_size_o = act_size_q[cur_q];
            state_d    = CLR_W;
         end
         CLR_W, SET_W: begin
            tmr_d = tmr_q + TW'(1);
            if (wait_done) begin
               tmr_d     = '0;
               ack_err_d = ack_err_q | wait_tout;
               state_d   = (state_q == CLR_W) ? SET_CHK : IDLE;
               if (state_q == SET_W) begin
                  act_en_d[cur_q]   = 1'b1;
                  act_from_d[cur_q] = new_from_q;
                  act_size_d[cur_q] = new_size_q;
               end
            end
         end
         SET_CHK: if (new_en_q && new_size_q != '0) state_d = SET;
         else begin
            act_en_d[cur_q]   = 1'b0;
            act_size_d[cur_q] = '0;
            state_d           = IDLE;
         end
         SET: begin
            map_op_o   = `OP_SET;
            map_from_o = new_from_q;
            map_size_o = new_size_q;
            state_d    = SET_W;
         end
         default: state_d = IDLE;
      endcase
      if (ctrl_hit) pending_d[wr_addr_i[AW-1:4]] = 1'b1;
   end

   // Sequencer state, snapshot and committed mapping; reset abandons any op in flight
   always_ff @(posedge clk200_i) begin
      if (!a8_rst_n_i) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         cur_q      <= '0;
         new_en_q   <= 1'b0;
         new_from_q <= '0;
         new_size_q <= '0;
         act_en_q   <= '0;
         act_from_q <= '{default: '0};
         act_size_q <= '{default: '0};
         tmr_q      <= '0;
         ack_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         cur_q      <= cur_d;
         new_en_q   <= new_en_d;
         new_from_q <= new_from_d;
         new_size_q <= new_size_d;
         act_en_q   <= act_en_d;
         act_from_q <= act_from_d;
         act_size_q <= act_size_d;
         tmr_q      <= tmr_d;
         ack_err_q  <= ack_err_d;
      end
   end
endmodule

// File: tb/tb_aperture_regs.sv
// tb_aperture_regs: randomized check of aperture_regs against a transaction-level commit model
`ifndef OP_NONE
`define OP_NONE  2'd0
`endif
`ifndef OP_SET
`define OP_SET   2'd1
`endif
`ifndef OP_CLEAR
`define OP_CLEAR 2'd2
`endif

module tb_aperture_regs;
   logic       clk = 1'b0, rst_n = 1'b0, wr_strobe = 1'b0, map_valid = 1'b1, hang = 1'b0;
   logic [7:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
   logic [7:0] rd_data, map_from, map_size, ap_enable;
   logic [1:0] map_op;
   logic       busy, ack_err;

   aperture_regs dut (
      .clk200_i(clk), .a8_rst_n_i(rst_n), .wr_strobe_i(wr_strobe), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .map_op_o(map_op),
      .map_from_o(map_from), .map_size_o(map_size), .map_valid_i(map_valid), .busy_o(busy),
      .ap_enable_o(ap_enable), .ack_err_o(ack_err)
   );

   initial forever #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [7:0]  mem_m [128];
   logic [7:0]  act_from_m [8];
   logic [7:0]  act_size_m [8];
   logic [7:0]  act_en_m;
   logic [17:0] ops[$], exp_ops[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 128; i++) mem_m[i] = '0;
      for (int i = 0; i < 8; i++) begin act_from_m[i] = '0; act_size_m[i] = '0; end
      act_en_m = '0;
   endtask

   // one commit of aperture k as software sees it: drop the old range, map the clamped new one
   task automatic m_commit(input int k);
      int from, sz, eff;
      from = int'(mem_m[k*16+4]);
      sz   = int'(mem_m[k*16+5]);
      eff  = (sz < 256 - from) ? sz : 256 - from;
      if (act_en_m[k] && act_size_m[k] != 0) exp_ops.push_back({`OP_CLEAR, act_from_m[k], act_size_m[k]});
      if (mem_m[k*16+15][0] && eff != 0) begin
         exp_ops.push_back({`OP_SET, 8'(from), 8'(eff)});
         act_en_m[k] = 1'b1; act_from_m[k] = 8'(from); act_size_m[k] = 8'(eff);
      end else begin
         act_en_m[k] = 1'b0; act_size_m[k] = '0;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_strobe = 1'b1; wr_addr = a; wr_data = d;
      if (a < 8'h80) begin
         mem_m[a[6:0]] = d;
         if (a[3:0] == 4'hF) m_commit(int'(a[6:4]));
      end
   endtask

   task automatic idle();
      @(negedge clk);
      wr_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      d = rd_data;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin @(negedge clk); n++; end
      check("idle", busy, 0);
   endtask

   task automatic check_ops();
      check("op_count", ops.size(), exp_ops.size());
      for (int i = 0; i < ops.size() && i < exp_ops.size(); i++) check("op", ops[i], exp_ops[i]);
      ops.delete();
      exp_ops.delete();
   endtask

   // page_map stand-in: logs every op cycle and stays busy for a random few cycles afterwards
   initial begin
      int lowcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (map_op !== `OP_NONE) begin
            ops.push_back({map_op, map_from, map_size});
            lowcnt = $urandom_range(0, 3);
         end else if (lowcnt > 0) lowcnt--;
         map_valid = !(hang || lowcnt > 0);
      end
   end

   task automatic rand_round();
      logic [7:0] mask, a, c, d;
      int nd;
      mask = 8'($urandom_range(1, 255));
      nd   = $urandom_range(2, 8);
      for (int j = 0; j < nd; j++) begin
         a = 8'($urandom);
         if (a[3:0] == 4'hF) a[3:0] = 4'hE;
         wr(a, 8'($urandom));
      end
      for (int k = 0; k < 8; k++)
         if (mask[k] && $urandom_range(0, 3) != 0) begin
            wr(8'(k*16+4), 8'($urandom_range(0, 255)));
            wr(8'(k*16+5), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 48)));
         end
      for (int k = 0; k < 8; k++)
         if (mask[k]) begin
            c = 8'($urandom);
            c[0] = ($urandom_range(0, 3) != 0);
            wr(8'(k*16+15), c);
            if ($urandom_range(0, 1) == 1) idle();
         end
      idle();
      wait_idle(2000);
      check_ops();
      check("rand_en", ap_enable, act_en_m);
      a = 8'($urandom_range(0, 127));
      rd(a, d);
      check("rand_rd", d, mem_m[a[6:0]]);
   endtask

   initial begin
      logic [7:0] d, old;
      m_reset();
      repeat (3) @(negedge clk);
      check("rst_op", map_op, `OP_NONE);
      check("rst_from", map_from, 0);
      check("rst_size", map_size, 0);
      check("rst_rd", rd_data, 0);
      check("rst_en", ap_enable, 0);
      check("rst_err", ack_err, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;

      wr(8'h05, 8'h04); wr(8'h04, 8'h80); wr(8'h0F, 8'h01); idle();
      wait_idle(100);
      check("set0_count", ops.size(), 1);
      if (ops.size() > 0) check("set0", ops[0], {`OP_SET, 8'h80, 8'h04});
      check_ops();
      check("en0", ap_enable, 8'h01);
      check("busy0", busy, 0);

      wr(8'h04, 8'h90); wr(8'h0F, 8'h01); idle();
      wait_idle(100);
      if (ops.size() == 2) begin
         check("move_clr", ops[0], {`OP_CLEAR, 8'h80, 8'h04});
         check("move_set", ops[1], {`OP_SET, 8'h90, 8'h04});
      end
      check_ops();

      wr(8'h15, 8'h02); wr(8'h14, 8'h10); wr(8'h35, 8'h03); wr(8'h34, 8'h20);
      wr(8'h1F, 8'h01); wr(8'h3F, 8'h01); idle();
      wait_idle(200);
      check_ops();
      check("en13", ap_enable, 8'h0B);

      wr(8'h24, 8'hFE); wr(8'h25, 8'h10); wr(8'h2F, 8'h01); idle();
      wait_idle(100);
      check("clamp", (ops.size() > 0) ? ops[ops.size()-1] : 18'h0, {`OP_SET, 8'hFE, 8'h02});
      check_ops();

      rd(8'h05, d); check("rd05", d, 8'h04);
      rd(8'h2F, d); check("rd2f", d, 8'h01);
      wr(8'h85, 8'hAA); wr(8'h8F, 8'h01); idle();
      @(negedge clk);
      check("unimpl_busy", busy, 0);
      rd(8'h85, d); check("rd85", d, 8'h00);
      rd(8'hFF, d); check("rdff", d, 8'h00);

      old = mem_m[6];
      rd_addr = 8'h06;
      wr(8'h06, 8'h5A);
      @(negedge clk);
      check("rd_old", rd_data, old);
      wr_strobe = 1'b0;
      @(negedge clk);
      check("rd_new", rd_data, 8'h5A);

      for (int r = 0; r < 30; r++) rand_round();

      wr(8'h4F, 8'h00); idle(); wait_idle(200); check_ops();
      hang = 1'b1;
      wr(8'h44, 8'h10); wr(8'h45, 8'h01); wr(8'h4F, 8'h01); idle();
      repeat (200) @(negedge clk);
      check("to_early_err", ack_err, 0);
      check("to_early_busy", busy, 1);
      wait_idle(150);
      check("to_err", ack_err, 1);
      check("to_en", ap_enable, act_en_m);
      check_ops();
      hang = 1'b0;
      wr(8'h4F, 8'h00); idle(); wait_idle(200);
      check_ops();
      check("err_sticky", ack_err, 1);

      wr(8'h5F, 8'h00); idle(); wait_idle(200); check_ops();
      rd_addr = 8'h55;
      hang = 1'b1;
      wr(8'h54, 8'h20); wr(8'h55, 8'h03); wr(8'h5F, 8'h01); idle();
      repeat (10) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      check_ops();
      rst_n = 1'b0;
      m_reset();
      @(negedge clk);
      check("r2_op", map_op, `OP_NONE);
      check("r2_from", map_from, 0);
      check("r2_size", map_size, 0);
      check("r2_busy", busy, 0);
      check("r2_en", ap_enable, 0);
      check("r2_err", ack_err, 0);
      check("r2_rd", rd_data, 0);
      hang = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_ops", ops.size(), 0);
      rd(8'h05, d); check("post_rst_rd05", d, 8'h00);

      for (int r = 0; r < 5; r++) rand_round();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
